// File: rtl/bitrev_sched.sv
`default_nettype none
// ============================================================================
// Module   : bitrev_sched
// Purpose  : Two-port round-robin front end for one iterative bit-reversal
//            engine. STEP bits are reversed per BUSY cycle; the finished word
//            is held on the output until downstream accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module bitrev_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_din,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_din,
    output logic                  req1_ready,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_id,
    input  logic                  dout_ready
);

    // Chunks per word and a counter wide enough that its top bit never wraps
    localparam int c_n_chunks = DATA_WIDTH / STEP;
    localparam int c_cnt_w    = $clog2(c_n_chunks) + 1;
    localparam logic [c_cnt_w-1:0] c_last_chunk = c_cnt_w'(c_n_chunks - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_src;
    logic [DATA_WIDTH-1:0] r_result;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_id;
    logic                  r_last_grant;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_id;
    logic                  r_dout_valid;

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_win_id;
    logic [DATA_WIDTH-1:0] w_win_din;
    logic                  w_last;
    logic [STEP-1:0]       w_chunk_rev;
    logic [DATA_WIDTH-1:0] w_result_nxt;
    logic [DATA_WIDTH-1:0] w_src_nxt;

    // Arbitration: a lone requester always wins; on a tie the one that did
    // not win last time is granted.
    assign w_idle     = (r_state == c_idle);
    assign req0_ready = w_idle & req0_valid & (~req1_valid |  r_last_grant);
    assign req1_ready = w_idle & req1_valid & (~req0_valid | ~r_last_grant);
    assign w_accept   = req0_ready | req1_ready;
    assign w_win_id   = req1_ready;
    assign w_win_din  = req1_ready ? req1_din : req0_din;
    assign w_last     = (r_cnt == c_last_chunk);

    // Low chunk of the source, bit-reversed
    for (genvar gi = 0; gi < STEP; gi++) begin : g_chunk_rev
        assign w_chunk_rev[gi] = r_src[STEP-1-gi];
    end

    // The first chunk reversed ends up in the top bits after N shifts
    if (STEP == DATA_WIDTH) begin : g_single_step
        assign w_result_nxt = w_chunk_rev;
        assign w_src_nxt    = '0;
    end else begin : g_multi_step
        assign w_result_nxt = {r_result[DATA_WIDTH-STEP-1:0], w_chunk_rev};
        assign w_src_nxt    = {{STEP{1'b0}}, r_src[DATA_WIDTH-1:STEP]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_accept)   w_state_nxt = c_busy;
            c_busy:  if (w_last)     w_state_nxt = c_done;
            c_done:  if (dout_ready) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Datapath: load on grant, shift/reverse while busy, hold result until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src        <= '0;
            r_result     <= '0;
            r_cnt        <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_dout       <= '0;
            r_dout_id    <= 1'b0;
            r_dout_valid <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_src        <= w_win_din;
                        r_result     <= '0;
                        r_cnt        <= '0;
                        r_id         <= w_win_id;
                        r_last_grant <= w_win_id;
                    end
                end
                c_busy: begin
                    r_src    <= w_src_nxt;
                    r_result <= w_result_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_dout       <= w_result_nxt;
                        r_dout_id    <= r_id;
                        r_dout_valid <= 1'b1;
                    end
                end
                c_done: begin
                    if (dout_ready) begin
                        r_dout_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign dout_id    = r_dout_id;

endmodule
`default_nettype wire

// File: tb/tb_bitrev_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitrev_sched
// Purpose  : Self-checking bench for bitrev_sched (32/4 main instance plus
//            8/8 and 16/1 parameter sweeps).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitrev_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_din, req1_din, dout;
    logic        dout_valid, dout_id, dout_ready;

    logic        s8_v0, s8_v1, s8_r0, s8_r1, s8_dv, s8_id, s8_dr;
    logic [7:0]  s8_d0, s8_d1, s8_dout;
    logic        s16_v0, s16_v1, s16_r0, s16_r1, s16_dv, s16_id, s16_dr;
    logic [15:0] s16_d0, s16_d1, s16_dout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        logic        id;
        int          cyc;
    } sb_t;
    sb_t  sbq[$];
    logic dv_prev = 1'b0;

    typedef struct {
        int          port;
        logic [31:0] din;
        logic [31:0] exp;
        logic        id;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    // Cycle counter used for latency and spacing measurements
    always @(posedge clk) cyc <= cyc + 1;

    bitrev_sched #(.DATA_WIDTH(32), .STEP(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_din(req0_din), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_din(req1_din), .req1_ready(req1_ready),
        .dout_valid(dout_valid), .dout(dout), .dout_id(dout_id), .dout_ready(dout_ready)
    );

    bitrev_sched #(.DATA_WIDTH(8), .STEP(8)) u8 (
        .clk(clk), .reset(reset),
        .req0_valid(s8_v0), .req0_din(s8_d0), .req0_ready(s8_r0),
        .req1_valid(s8_v1), .req1_din(s8_d1), .req1_ready(s8_r1),
        .dout_valid(s8_dv), .dout(s8_dout), .dout_id(s8_id), .dout_ready(s8_dr)
    );

    bitrev_sched #(.DATA_WIDTH(16), .STEP(1)) u16 (
        .clk(clk), .reset(reset),
        .req0_valid(s16_v0), .req0_din(s16_d0), .req0_ready(s16_r0),
        .req1_valid(s16_v1), .req1_din(s16_d1), .req1_ready(s16_r1),
        .dout_valid(s16_dv), .dout(s16_dout), .dout_id(s16_id), .dout_ready(s16_dr)
    );

    function automatic logic [31:0] rev(input logic [31:0] x, input int w);
        logic [31:0] r = '0;
        for (int i = 0; i < w; i++) r[i] = x[w-1-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard for the main instance: push on accept, pop on output handshake
    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
            dv_prev = 1'b0;
        end else begin
            check("ready_exclusive", {63'b0, req0_ready & req1_ready}, 64'd0);
            if (dout_valid && !dv_prev) begin
                if (sbq.size() == 0) check("sb_unexpected_out", 64'd1, 64'd0);
                else check("sb_latency", 64'(cyc - sbq[0].cyc), 64'd9);
            end
            if (dout_valid && dout_ready && sbq.size() > 0) begin
                check("sb_dout", {32'b0, dout}, {32'b0, sbq[0].data});
                check("sb_id", {63'b0, dout_id}, {63'b0, sbq[0].id});
                void'(sbq.pop_front());
            end
            if (req0_valid && req0_ready) sbq.push_back('{rev(req0_din, 32), 1'b0, cyc});
            if (req1_valid && req1_ready) sbq.push_back('{rev(req1_din, 32), 1'b1, cyc});
            dv_prev = dout_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input int port, input logic [31:0] d, output int acc);
        bit ok = 1'b0;
        if (port == 0) begin req0_valid = 1'b1; req0_din = d; end
        else           begin req1_valid = 1'b1; req1_din = d; end
        #1;
        for (int i = 0; i < 60 && !ok; i++) begin
            if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) ok = 1'b1;
            else tick();
        end
        acc = cyc;
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic wait_dv();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (dout_valid) ok = 1'b1;
            else tick();
        end
        if (!ok) check("dout_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic sweep8();
        for (int n = 0; n < 1000; n++) begin
            int p = $urandom_range(0, 1);
            logic [31:0] d = $urandom;
            int acc;
            bit ok = 1'b0;
            if (p == 0) begin s8_v0 = 1'b1; s8_d0 = d[7:0]; end
            else        begin s8_v1 = 1'b1; s8_d1 = d[7:0]; end
            #1;
            for (int i = 0; i < 20 && !ok; i++) begin
                if ((p == 0 && s8_r0) || (p == 1 && s8_r1)) ok = 1'b1; else tick();
            end
            if (!ok) check("s8_accept_timeout", 64'd0, 64'd1);
            acc = cyc;
            tick();
            s8_v0 = 1'b0; s8_v1 = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                if (s8_dv) ok = 1'b1; else tick();
            end
            check("s8_latency", 64'(cyc - acc), 64'd2);
            check("s8_dout", {56'b0, s8_dout}, {32'b0, rev({24'b0, d[7:0]}, 8)});
            check("s8_id", {63'b0, s8_id}, 64'(p));
            tick();
        end
    endtask

    task automatic sweep16();
        for (int n = 0; n < 1000; n++) begin
            int p = $urandom_range(0, 1);
            logic [31:0] d = $urandom;
            int acc;
            bit ok = 1'b0;
            if (p == 0) begin s16_v0 = 1'b1; s16_d0 = d[15:0]; end
            else        begin s16_v1 = 1'b1; s16_d1 = d[15:0]; end
            #1;
            for (int i = 0; i < 20 && !ok; i++) begin
                if ((p == 0 && s16_r0) || (p == 1 && s16_r1)) ok = 1'b1; else tick();
            end
            if (!ok) check("s16_accept_timeout", 64'd0, 64'd1);
            acc = cyc;
            tick();
            s16_v0 = 1'b0; s16_v1 = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                if (s16_dv) ok = 1'b1; else tick();
            end
            check("s16_latency", 64'(cyc - acc), 64'd17);
            check("s16_dout", {48'b0, s16_dout}, {32'b0, rev({16'b0, d[15:0]}, 16)});
            check("s16_id", {63'b0, s16_id}, 64'(p));
            tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc;
        int accs[3];
        int idx;
        int port;
        bit ok;
        bit seen;
        logic [31:0] words[3];

        vecs[0] = '{0, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[1] = '{1, 32'hDEAD_BEEF, 32'hF77D_B57B, 1'b1};
        vecs[2] = '{0, 32'h1234_5678, 32'h1E6A_2C48, 1'b0};
        vecs[3] = '{1, 32'hF000_0000, 32'h0000_000F, 1'b1};
        vecs[4] = '{0, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0};
        vecs[5] = '{1, 32'h0000_0003, 32'hC000_0000, 1'b1};

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_din = '0; req1_din = '0; dout_ready = 1'b0;
        s8_v0 = 1'b0; s8_v1 = 1'b0; s8_d0 = '0; s8_d1 = '0; s8_dr = 1'b1;
        s16_v0 = 1'b0; s16_v1 = 1'b0; s16_d0 = '0; s16_d1 = '0; s16_dr = 1'b1;
        tick();
        tick();
        check("reset_dout_valid", {63'b0, dout_valid}, 64'd0);
        check("reset_dout", {32'b0, dout}, 64'd0);
        check("reset_dout_id", {63'b0, dout_id}, 64'd0);
        reset = 1'b0;

        // Single word, latency and return to idle
        dout_ready = 1'b1;
        send(0, 32'h0000_0001, acc);
        wait_dv();
        check("t1_latency", 64'(cyc - acc), 64'd9);
        check("t1_dout", {32'b0, dout}, 64'h8000_0000);
        check("t1_id", {63'b0, dout_id}, 64'd0);
        tick();
        check("t1_dv_drop", {63'b0, dout_valid}, 64'd0);
        req0_valid = 1'b1;
        #1;
        check("t1_ready_again", {63'b0, req0_ready}, 64'd1);
        req0_valid = 1'b0;
        tick();

        // Table of vectors
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].port, vecs[v].din, acc);
            wait_dv();
            check("vec_latency", 64'(cyc - acc), 64'd9);
            check("vec_dout", {32'b0, dout}, {32'b0, vecs[v].exp});
            check("vec_id", {63'b0, dout_id}, {63'b0, vecs[v].id});
            tick();
        end

        // Both requesters continuously valid from reset: grants alternate
        do_reset();
        req0_din = 32'h1234_5678; req1_din = 32'hF000_0000;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            #1;
            for (int i = 0; i < 30 && !ok; i++) begin
                if (req0_ready || req1_ready) ok = 1'b1; else tick();
            end
            if (!ok) check("t2_grant_timeout", 64'd0, 64'd1);
            port = req1_ready ? 1 : 0;
            check("t2_grant_order", 64'(port), 64'(k % 2));
            tick();
            wait_dv();
            check("t2_dout", {32'b0, dout}, (port == 1) ? 64'h0000_000F : 64'h1E6A_2C48);
            check("t2_id", {63'b0, dout_id}, 64'(port));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Backpressure: output held stable, no grants while full
        dout_ready = 1'b0;
        send(0, 32'hA5A5_A5A5, acc);
        wait_dv();
        req0_valid = 1'b1; req1_valid = 1'b1; req1_din = 32'h0000_0001;
        #1;
        for (int i = 0; i < 20; i++) begin
            check("t3_hold_valid", {63'b0, dout_valid}, 64'd1);
            check("t3_hold_dout", {32'b0, dout}, 64'hA5A5_A5A5);
            check("t3_hold_id", {63'b0, dout_id}, 64'd0);
            check("t3_readies_low", {62'b0, req0_ready, req1_ready}, 64'd0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        dout_ready = 1'b1;
        tick();
        check("t3_release_dv", {63'b0, dout_valid}, 64'd0);
        check("t3_release_keep_dout", {32'b0, dout}, 64'hA5A5_A5A5);
        req1_valid = 1'b1;
        #1;
        check("t3_idle_after_release", {63'b0, req1_ready}, 64'd1);
        req1_valid = 1'b0;
        tick();

        // One requester continuously valid: back-to-back at the minimum interval
        words[0] = 32'h0000_0003; words[1] = 32'h8000_0000; words[2] = 32'hFFFF_FFFF;
        idx = 0;
        req1_din = words[0];
        req1_valid = 1'b1;
        for (int i = 0; i < 100 && idx < 3; i++) begin
            #1;
            if (req1_ready) begin
                accs[idx] = cyc;
                idx++;
                tick();
                if (idx < 3) req1_din = words[idx];
                else req1_valid = 1'b0;
            end else begin
                tick();
            end
        end
        req1_valid = 1'b0;
        check("t4_accept_count", 64'(idx), 64'd3);
        check("t4_spacing_01", 64'(accs[1] - accs[0]), 64'd10);
        check("t4_spacing_12", 64'(accs[2] - accs[1]), 64'd10);
        wait_dv();
        check("t4_last_dout", {32'b0, dout}, 64'hFFFF_FFFF);
        check("t4_last_id", {63'b0, dout_id}, 64'd1);
        tick();

        // Reset mid-BUSY after a port-0 grant: arbitration state restored
        send(0, 32'h1111_1111, acc);
        wait_dv();
        tick();
        send(0, 32'h2222_2222, acc);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_dv_after_reset", {63'b0, dout_valid}, 64'd0);
        check("t5_dout_after_reset", {32'b0, dout}, 64'd0);
        check("t5_id_after_reset", {63'b0, dout_id}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (dout_valid) seen = 1'b1;
            tick();
        end
        check("t5_no_discarded_output", {63'b0, seen}, 64'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("t5_tie_grant0", {62'b0, req0_ready, req1_ready}, 64'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Parameter sweeps against a full-width reverse model
        sweep8();
        sweep16();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bitrev_sched.md
Name: bitrev_sched

Overview:
- Shares one iterative bit-reversal engine between two requesters.
- Round-robin arbitration with valid/ready handshakes on both input ports.
- The engine reverses STEP bits per cycle. The result is held on a single output port until it is accepted.
- Sits in front of consumers that need bit-reversed words, e.g. FFT index reordering or CRC reflection, where a full-width combinational reverser per requester is not wanted.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- STEP, 4, bits processed per BUSY cycle.
  - Must divide DATA_WIDTH; STEP = DATA_WIDTH is legal.
  - N = DATA_WIDTH/STEP chunks per word.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a word.
- req0_din  input  DATA_WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle when req0_valid is also high.
- req1_valid  input  1  requester 1 has a word.
- req1_din  input  DATA_WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle when req1_valid is also high.
- dout_valid  output  1  dout/dout_id hold a finished result.
- dout  output  DATA_WIDTH  bit-reversed word: dout[i] = din[DATA_WIDTH-1-i].
- dout_id  output  1  index of the requester that supplied the word.
- dout_ready  input  1  downstream accepts the result.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values:
  - State = IDLE; dout_valid = 0; dout = 0; dout_id = 0.
  - Chunk counter = 0; last_grant = 1, so requester 0 wins the first tie.
- req*_ready are combinational from state, last_grant and both req*_valid. dout_valid, dout and dout_id are registered.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Grant the winner by asserting its ready. At most one ready is high.
  - Only req0_valid high: req0_ready = 1. Only req1_valid high: req1_ready = 1.
  - Both high: grant the requester != last_grant.
  - Neither high: both readies = 0.
  - On handshake edge: load src shift register with the winner's din; clear result; cnt = 0; id = winner; last_grant = winner; go to BUSY.
- BUSY:
  - Both readies = 0.
  - Each edge: result <= {result[DATA_WIDTH-STEP-1:0], bit-reverse(src[STEP-1:0])}; src >>= STEP; cnt++.
  - When STEP = DATA_WIDTH, result <= bit-reverse(src) directly.
  - On the edge where cnt == N-1: go to DONE, dout <= final result, dout_id <= id, dout_valid <= 1.
  - Input valids are ignored in BUSY; requesters must hold valid and data until ready.
- DONE:
  - Both readies = 0. dout, dout_id and dout_valid are held stable while dout_ready = 0, for any number of cycles.
  - dout_valid and dout_ready both high at an edge: dout_valid <= 0, go to IDLE. dout keeps its last value.
  - No same-cycle new accept.
- Timing:
  - Accept in cycle 0; BUSY in cycles 1..N; dout_valid first high in cycle N+1.
  - Minimum issue interval is N+2 cycles per word (N = 8 gives 10).
- Fairness:
  - With both requesters continuously valid, grants alternate 0,1,0,1,...
  - A single active requester is granted back-to-back; last_grant does not block it.
- Reset mid-operation (BUSY or DONE): the in-flight word is discarded without output, dout_valid drops to 0 the next cycle, and all reset values are restored.
- Unused upper counter bits must not affect wrap; cnt is sized $clog2(N)+1.

Test Plan:
1. Defaults (32/4). Single request on port 0, din = 0x00000001, dout_ready = 1 → dout_valid high exactly 9 cycles after accept cycle, dout = 0x80000000, dout_id = 0, dout_valid low the following cycle, req0_ready high again one cycle later.
2. Both ports valid from reset, port0 din = 0x12345678, port1 din = 0xF0000000, dout_ready = 1 → first grant port 0, result 0x1E6A2C48 with id 0; then port 1 granted, result 0x0000000F with id 1; a third pair is granted port 0 first.
3. Backpressure: din = 0xA5A5A5A5, dout_ready held 0 for 20 cycles after dout_valid → dout = 0xA5A5A5A5 and id held stable with valid high throughout; both readies stay 0; release → IDLE next cycle.
4. Port 1 only, valid continuously, three words 0x00000003, 0x80000000, 0xFFFFFFFF → outputs 0xC0000000, 0x00000001, 0xFFFFFFFF, all with id 1, accepts spaced exactly 10 cycles apart.
5. Reset asserted in cycle 4 of BUSY → next cycle state IDLE, dout_valid = 0, dout = 0; a subsequent simultaneous request pair is granted to port 0.
6. Parameter sweeps with random data checked against a full-width reverse model, 1000 words each:
   - DATA_WIDTH = 8, STEP = 8 (N = 1): latency is 2 cycles.
   - DATA_WIDTH = 16, STEP = 1 (N = 16): latency is 17 cycles.
